// File: rtl/intc85_pic.sv
// 8085 interrupt priority controller: edge-latched requests, mask, fixed priority, RST n vector on INTA_.
// Define INTC85_LEVEL_TRIG_EN for level-sensitive request capture (IRR follows IRQ every cycle).
module intc85_pic #(
  parameter int unsigned               DATASIZE = 8,
  parameter logic [DATASIZE-1:0]       BASEPORT = 8'h20
) (
  input  logic                CLK,
  input  logic                RST_,
  inout  wire  [DATASIZE-1:0] ADDRDATA,
  input  logic                ALE,
  input  logic                IOM_,
  input  logic                RD_,
  input  logic                WR_,
  input  logic                INTA_,
  input  logic [7:0]          IRQ,
  output logic                INTR
);

  localparam logic [DATASIZE-1:0] PORT_ISR = BASEPORT;
  localparam logic [DATASIZE-1:0] PORT_IMR = BASEPORT + DATASIZE'(1);
  localparam logic [DATASIZE-1:0] PORT_IRR = BASEPORT + DATASIZE'(2);

  logic [DATASIZE-1:0] irr, isr, imr, alat, vec, wdat;
  logic [DATASIZE-1:0] irr_n, isr_n, isr_eoi, vec_n, pend;
  logic [DATASIZE-1:0] bus_out;
  logic [7:0]          irq_q;
  logic                ackv, ackv_n, inta_q, wr_q;
  logic                inta_fall, wr_rise, intr_n, bus_oe;
  logic                sel_isr, sel_imr, sel_irr;
  logic [3:0]          req, ack;

  // {found, index} of the highest-priority pending line not blocked by an
  // in-service line of equal or higher priority.
  function automatic logic [3:0] resolve(input logic [7:0] p, input logic [7:0] busy);
    logic [3:0] r;
    logic       stop;
    r    = '0;
    stop = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!stop) begin
        if (busy[i]) begin
          stop = 1'b1;
        end else if (p[i]) begin
          r    = {1'b1, 3'(i)};
          stop = 1'b1;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    sel_isr   = IOM_ && (alat == PORT_ISR);
    sel_imr   = IOM_ && (alat == PORT_IMR);
    sel_irr   = IOM_ && (alat == PORT_IRR);
    inta_fall = inta_q && !INTA_;
    wr_rise   = !wr_q && WR_;
    pend      = irr & ~imr;
    req       = resolve(pend[7:0], isr[7:0]);

    // EOI is folded in before the acknowledge resolves, so a same-cycle
    // EOI can unblock the line being acknowledged.
    isr_eoi = isr;
    if (wr_rise && sel_isr) begin
      if (wdat[7]) begin
        for (int unsigned i = 0; i < 8; i++) begin
          if (isr[i] && (isr[7:0] & ((8'd1 << i) - 8'd1)) == 8'd0) isr_eoi[i] = 1'b0;
        end
      end else if (wdat[7:6] == 2'b01) begin
        isr_eoi[wdat[2:0]] = 1'b0;
      end
    end
    ack = resolve(pend[7:0], isr_eoi[7:0]);

    isr_n = isr_eoi;
    irr_n = irr;
    vec_n = vec;
    if (inta_fall) begin
      if (ack[3]) begin
        vec_n             = DATASIZE'({2'b11, ack[2:0], 3'b111});
        isr_n[ack[2:0]]   = 1'b1;
`ifndef INTC85_LEVEL_TRIG_EN
        irr_n[ack[2:0]]   = 1'b0;
`endif
      end else begin
        vec_n = DATASIZE'(8'hFF);
      end
    end
`ifdef INTC85_LEVEL_TRIG_EN
    irr_n = DATASIZE'(IRQ);
`else
    irr_n = irr_n | DATASIZE'(IRQ & ~irq_q);
`endif

    if (inta_fall)  ackv_n = 1'b1;
    else if (INTA_) ackv_n = 1'b0;
    else            ackv_n = ackv;

    intr_n = (ackv || inta_fall) ? 1'b0 : req[3];
  end

  always_ff @(posedge CLK) begin
    if (!RST_) begin
      irr   <= '0;
      isr   <= '0;
      imr   <= '1;
      INTR  <= 1'b0;
      alat  <= '0;
      vec   <= '1;
      ackv  <= 1'b0;
      irq_q <= '0;
      inta_q <= 1'b1;
      wr_q  <= 1'b1;
      wdat  <= '0;
    end else begin
      if (ALE) alat <= ADDRDATA;
      if (!WR_) wdat <= ADDRDATA;
      irq_q  <= IRQ;
      inta_q <= INTA_;
      wr_q   <= WR_;
      irr    <= irr_n;
      isr    <= isr_n;
      vec    <= vec_n;
      ackv   <= ackv_n;
      INTR   <= intr_n;
      if (wr_rise && sel_imr) imr <= wdat;
    end
  end

  always_comb begin
    bus_oe  = 1'b0;
    bus_out = '0;
    if (RST_) begin
      if (!INTA_ && ackv) begin
        bus_oe  = 1'b1;
        bus_out = vec;
      end else if (!RD_ && sel_isr) begin
        bus_oe  = 1'b1;
        bus_out = isr;
      end else if (!RD_ && sel_imr) begin
        bus_oe  = 1'b1;
        bus_out = imr;
      end else if (!RD_ && sel_irr) begin
        bus_oe  = 1'b1;
        bus_out = irr;
      end
    end
  end

  assign ADDRDATA = bus_oe ? bus_out : 'z;

endmodule

// File: doc/intc85_pic.md
Name: intc85_pic

Overview:
- Interrupt priority controller that sits directly upstream of the 8085 core and drives its INTR pin.
- Latches up to 8 external requests, masks them, and resolves fixed priority (IRQ[0] highest).
- During INTA_ low it returns an RST n opcode on the multiplexed ADDRDATA bus.
- Its mask and status registers are reached as I/O ports over the core's multiplexed bus, using ALE, IOM_, RD_ and WR_.

Parameters:
- DATASIZE, 8, width of ADDRDATA and of every internal register.
- BASEPORT, 8'h20, I/O port base; the block decodes BASEPORT+0 to BASEPORT+2.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_  input  1  synchronous active-low reset, sampled on CLK rising edge.
- ADDRDATA  inout  DATASIZE  multiplexed AD bus; high-Z unless the block is driving.
- ALE  input  1  address latch enable from the core.
- IOM_  input  1  1 = I/O cycle.
- RD_  input  1  active-low read strobe.
- WR_  input  1  active-low write strobe.
- INTA_  input  1  active-low interrupt acknowledge.
- IRQ  input  8  request lines, active high.
- INTR  output  1  registered interrupt request to the core.

Behaviour:
- Reset (RST_=0 at CLK edge): IRR=0, ISR=0, IMR=8'hFF (all masked), INTR=0, alat=0, vec=8'hFF, ackv=0, irq_q=0, inta_q=1, wr_q=1, wdat=0. ADDRDATA is high-Z while in reset. Reset wins over every simultaneous event.
- Address latch: every edge with ALE=1, alat<=ADDRDATA.
- Port select: sel_n = (IOM_=1) && (alat==BASEPORT+n), for n = 0..2.
- Request latch: irq_q<=IRQ each cycle. A rising edge on IRQ[i] (IRQ[i]=1, irq_q[i]=0) sets IRR[i].
- Acknowledge: inta_fall = (inta_q=1 && INTA_=0). On that edge:
  - p = lowest index with IRR&~IMR set and no ISR bit at index <= p.
  - If p exists: vec<=8'hC7|(p<<3), ISR[p]<=1, IRR[p]<=0.
  - If none (spurious): vec<=8'hFF (RST 7), ISR and IRR unchanged.
  - ackv<=1.
  - ackv clears when INTA_ is sampled high.
  - If an IRQ[p] edge arrives in the same cycle as the ack that clears IRR[p], the set wins and the IRR bit stays 1.
- INTR (registered, 1-cycle latency): INTR<=1 iff some unmasked IRR bit has higher priority than the highest-priority ISR bit (any unmasked IRR bit if ISR=0). INTR is forced 0 while ackv=1.
- Bus drive (combinational):
  - INTA_=0 && ackv=1: ADDRDATA=vec.
  - Else RD_=0 && sel_0: ADDRDATA=ISR; RD_=0 && sel_1: ADDRDATA=IMR; RD_=0 && sel_2: ADDRDATA=IRR.
  - Else high-Z.
  - The INTA_ drive has priority over RD_.
- Write:
  - wr_q<=WR_. While WR_=0, wdat<=ADDRDATA.
  - On the WR_ rising edge (wr_q=0, WR_=1), commit wdat:
  - sel_1: IMR<=wdat.
  - sel_0 with wdat[7]=1: non-specific EOI, clears the highest-priority set ISR bit; no-op if ISR=0.
  - sel_0 with wdat[7:6]=2'b01: specific EOI, clears ISR[wdat[2:0]].
  - Other sel_0 values and writes to sel_2 are ignored.
- EOI and inta_fall in the same cycle: the EOI clear is applied first, then the ack set.
- Reset mid-acknowledge: ackv=0, the bus is released at once, and a pending vector is lost.

Optional Feature:
- Macro INTC85_LEVEL_TRIG_EN.
- Defined: IRR<=IRQ every cycle (level sensitive). An ack does not clear IRR; the device must deassert IRQ before EOI or it re-requests.
- Undefined: edge-triggered latch as described in Behaviour.

Test Plan:
1. Reset, then read port 8'h21 -> ADDRDATA=8'hFF. Read port 8'h20 -> 8'h00. INTR=0.
2. Write 8'h00 to 8'h21; pulse IRQ[2] -> INTR=1 on the second edge after the IRQ edge. INTA_ low -> ADDRDATA=8'hD7, ISR=8'h04, IRR=8'h00, INTR=0.
3. Raise IRQ[5] and IRQ[1] in the same cycle -> first ack returns 8'hCF (RST 1). Without EOI, INTR stays 0 for IRQ[5]. Write 8'h80 to 8'h20 -> ISR=0, INTR=1, next ack returns 8'hEF.
4. IMR=8'hFE, pulse IRQ[3] -> INTR stays 0 and IRR=8'h08. Write IMR=8'h00 -> INTR=1.
5. Spurious ack (INTA_ low with IRR=0) -> ADDRDATA=8'hFF, ISR unchanged. Assert RST_=0 with INTA_ still low -> bus high-Z on the next edge.
6. With INTC85_LEVEL_TRIG_EN defined, hold IRQ[0] high through ack and EOI -> INTR reasserts after EOI and a second ack returns 8'hC7.
